// File: rtl/jtopll_pkg.sv
// Shared definitions for the JTOPLL host-side write sequencer.
package jtopll_pkg;

    // Sequencer state encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ADDR   = 3'd1;
    localparam logic [2:0] ST_WAIT_A = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_WAIT_D = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_ADDR   = ST_ADDR,
        S_WAIT_A = ST_WAIT_A,
        S_DATA   = ST_DATA,
        S_WAIT_D = ST_WAIT_D
    } state_t;

    // Chip wait times in cen ticks after an address / data write
    localparam int OPLL_AW_WAIT = 12;
    localparam int OPLL_DW_WAIT = 84;

    // Width needed to hold the larger of two wait values (at least one bit)
    function automatic int wait_cw(input int aw, input int dw);
        int m;
        int w;
        m = (aw > dw) ? aw : dw;
        w = 1;
        while ((1 << w) <= m) w++;
        return w;
    endfunction

endpackage

// File: rtl/jtopl_sfifo.sv
// Small synchronous FIFO with occupancy output; read data is the current head.
module jtopl_sfifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16,
    localparam int PW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic             rst,
    input  logic             clk,
    input  logic [WIDTH-1:0] din,
    input  logic             push,
    output logic             ready,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign ready = (level < LW'(DEPTH));
    assign wr_en = push && ready;
    assign rd_en = pop && (level != '0);
    assign dout  = mem[rd_ptr];

    // Storage: data only, no reset needed
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally (DEPTH is a power of two); level tells full from empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/jtopll_wrseq.sv
// OPLL register write sequencer: queues (reg,val) requests and issues them as
// address/data strobe pairs, honouring the chip's post-write waits in cen ticks.
module jtopll_wrseq
    import jtopll_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int AW_WAIT   = OPLL_AW_WAIT,
    parameter int DW_WAIT   = OPLL_DW_WAIT,
    parameter int SKIP_SAME = 1,
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          cen,
    input  logic [7:0]    req_reg,
    input  logic [7:0]    req_val,
    input  logic          req_valid,
    output logic          req_ready,
    output logic          write,
    output logic          addr,
    output logic [7:0]    dout,
    output logic          busy,
    output logic [LW-1:0] level
);

    localparam int CW = wait_cw(AW_WAIT, DW_WAIT);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [7:0]    cur_reg;
    logic [7:0]    cur_val;
    logic [7:0]    last_reg;
    logic          last_vld;
    logic [15:0]   head;
    logic          pop;
    logic          skip_addr;

    jtopl_sfifo #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .rst   (rst),
        .clk   (clk),
        .din   ({req_reg, req_val}),
        .push  (req_valid),
        .ready (req_ready),
        .pop   (pop),
        .dout  (head),
        .level (level)
    );

    // A new entry starts only from IDLE with the wait fully elapsed
    assign pop       = (state == S_IDLE) && (level != '0) && (cnt == '0);
    assign skip_addr = (SKIP_SAME != 0) && last_vld && (head[15:8] == last_reg);
    assign busy      = (level != '0) || (state != S_IDLE);

    // Sequencer: strobes are registered and last one clk; addr/dout hold between strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            cur_reg  <= '0;
            cur_val  <= '0;
            last_reg <= '0;
            last_vld <= 1'b0;
            write    <= 1'b0;
            addr     <= 1'b0;
            dout     <= '0;
        end else begin
            write <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        cur_reg <= head[15:8];
                        cur_val <= head[7:0];
                        state   <= skip_addr ? S_DATA : S_ADDR;
                    end
                end
                S_ADDR: begin
                    write    <= 1'b1;
                    addr     <= 1'b0;
                    dout     <= cur_reg;
                    last_reg <= cur_reg;
                    last_vld <= 1'b1;
                    cnt      <= CW'(AW_WAIT);
                    state    <= S_WAIT_A;
                end
                S_WAIT_A: begin
                    if (cnt == '0)  state <= S_DATA;
                    else if (cen)   cnt   <= cnt - 1'b1;
                end
                S_DATA: begin
                    write <= 1'b1;
                    addr  <= 1'b1;
                    dout  <= cur_val;
                    cnt   <= CW'(DW_WAIT);
                    state <= S_WAIT_D;
                end
                S_WAIT_D: begin
                    if (cnt == '0)  state <= S_IDLE;
                    else if (cen)   cnt   <= cnt - 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtopll_wrseq.sv
// Bench for jtopll_wrseq: expected strobe sequences come from a request-level
// model (address strobe unless same register is re-selected, then data strobe),
// and spacing is measured in cen ticks between observed strobes.
module tb_jtopll_wrseq;

    localparam int AW = 12;
    localparam int DW = 84;

    typedef struct {
        logic       a;
        logic [7:0] d;
    } stb_t;

    typedef struct {
        logic       a;
        logic [7:0] d;
        int         t;
    } obs_t;

    logic       clk;
    logic       rst;
    logic       cen;
    logic [7:0] req_reg, req_val;
    logic       req_valid, req_ready;
    logic       write, addr, busy;
    logic [7:0] dout;
    logic [2:0] level;

    logic [7:0] r0_reg, r0_val;
    logic       r0_valid, r0_ready;
    logic       write0, addr0, busy0;
    logic [7:0] dout0;
    logic [2:0] level0;

    int   errors = 0;
    int   checks = 0;
    int   tick   = 0;
    int   cen_mode = 1;
    int   phase  = 0;
    obs_t obs[$];
    obs_t obs0[$];
    stb_t expq[$];
    logic       m_last_vld = 1'b0;
    logic [7:0] m_last_reg = 8'h00;

    jtopll_wrseq #(.DEPTH(4), .AW_WAIT(AW), .DW_WAIT(DW), .SKIP_SAME(1)) dut (
        .rst(rst), .clk(clk), .cen(cen),
        .req_reg(req_reg), .req_val(req_val), .req_valid(req_valid), .req_ready(req_ready),
        .write(write), .addr(addr), .dout(dout), .busy(busy), .level(level)
    );

    jtopll_wrseq #(.DEPTH(4), .AW_WAIT(2), .DW_WAIT(3), .SKIP_SAME(0)) dut0 (
        .rst(rst), .clk(clk), .cen(cen),
        .req_reg(r0_reg), .req_val(r0_val), .req_valid(r0_valid), .req_ready(r0_ready),
        .write(write0), .addr(addr0), .dout(dout0), .busy(busy0), .level(level0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // cen: 0 = stuck low, 1 = every 4th clk, 2 = random
    initial begin
        cen = 1'b0;
        forever begin
            @(negedge clk);
            phase++;
            case (cen_mode)
                0:       cen = 1'b0;
                1:       cen = ((phase % 4) == 0);
                default: cen = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (cen) tick++;
        end
    end

    // Strobe monitors, sampled just after the active edge
    initial begin
        obs_t o;
        forever begin
            @(posedge clk);
            #1;
            if (write === 1'b1) begin
                o.a = addr; o.d = dout; o.t = tick;
                obs.push_back(o);
            end
            if (write0 === 1'b1) begin
                o.a = addr0; o.d = dout0; o.t = tick;
                obs0.push_back(o);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic chk_ge(input string tag, input int got, input int lo);
        checks++;
        assert (got >= lo) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected>=%0d", tag, got, lo);
        end
    endtask

    task automatic model_push(input logic [7:0] r, input logic [7:0] v);
        stb_t s;
        if (!(m_last_vld && r == m_last_reg)) begin
            s.a = 1'b0; s.d = r;
            expq.push_back(s);
            m_last_reg = r;
            m_last_vld = 1'b1;
        end
        s.a = 1'b1; s.d = v;
        expq.push_back(s);
    endtask

    // Called at a negedge; returns at a negedge with the request accepted
    task automatic push(input logic [7:0] r, input logic [7:0] v, output int waited);
        int n;
        n = 0;
        req_reg = r; req_val = v; req_valid = 1'b1;
        while (!req_ready && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready_timeout", 32'(n >= 4000), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        model_push(r, v);
        waited = n;
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int k;
        k = 0;
        while (obs.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("strobe_wait_timeout", 32'(obs.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("idle_wait_timeout", 32'(busy), 32'd0);
    endtask

    task automatic check_strobes(input string tag, input bit exact);
        int n, w, g;
        chk({tag, "_count"}, 32'(obs.size()), 32'(expq.size()));
        n = (obs.size() < expq.size()) ? obs.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_strobe%0d", tag, i), {23'd0, obs[i].a, obs[i].d}, {23'd0, expq[i].a, expq[i].d});
            if (i > 0) begin
                w = expq[i-1].a ? DW : AW;
                g = obs[i].t - obs[i-1].t;
                if (exact) chk($sformatf("%s_gap%0d", tag, i), 32'(g), 32'(w));
                else       chk_ge($sformatf("%s_gap%0d", tag, i), g, w);
            end
        end
        obs.delete();
        expq.delete();
    endtask

    initial begin
        int w;
        logic [7:0] r;
        rst = 1'b1;
        req_valid = 1'b0; req_reg = 8'h00; req_val = 8'h00;
        r0_valid = 1'b0; r0_reg = 8'h00; r0_val = 8'h00;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Single request, cen every 4 clk
        cen_mode = 1;
        push(8'h10, 8'h5A, w);
        wait_strobes(2, 1000);
        wait_idle(2000);
        chk("single_busy_fall_ticks", 32'(tick - obs[1].t), 32'(DW));
        chk("single_addr_hold", 32'(addr), 32'd1);
        chk("single_dout_hold", 32'(dout), 32'h5A);
        check_strobes("single", 1'b1);

        // Same register twice: second request is data-only
        push(8'h30, 8'h11, w);
        push(8'h30, 8'h22, w);
        wait_idle(3000);
        check_strobes("same_reg", 1'b1);

        // Overfill: one in flight plus four queued, sixth held until a pop
        for (int i = 0; i < 5; i++) push(8'h60 + 8'(i), 8'hA0 + 8'(i), w);
        chk("full_level", 32'(level), 32'd4);
        chk("full_ready", 32'(req_ready), 32'd0);
        push(8'h65, 8'hA5, w);
        chk_ge("held_cycles", w, 10);
        chk("held_level", 32'(level), 32'd4);
        wait_idle(6000);
        check_strobes("overfill", 1'b1);

        // cen stuck low for 200 clk during WAIT_D
        push(8'h20, 8'h33, w);
        wait_strobes(2, 1000);
        repeat (10) @(negedge clk);
        cen_mode = 0;
        w = obs.size();
        repeat (200) @(negedge clk);
        chk("stall_no_strobe", 32'(obs.size()), 32'(w));
        chk("stall_busy", 32'(busy), 32'd1);
        cen_mode = 1;
        wait_idle(2000);
        chk("stall_wait_ticks", 32'(tick - obs[1].t), 32'(DW));
        check_strobes("stall", 1'b1);

        // Push and pop on the same edge at level 2
        push(8'h50, 8'h01, w);
        push(8'h51, 8'h02, w);
        push(8'h52, 8'h03, w);
        chk("pp_level_before", 32'(level), 32'd2);
        wait_strobes(2, 1000);
        w = 0;
        while (tick < obs[1].t + DW && w < 2000) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        chk("pp_level_at_pop", 32'(level), 32'd2);
        req_reg = 8'h53; req_val = 8'h04; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        model_push(8'h53, 8'h04);
        chk("pp_level_after", 32'(level), 32'd2);
        wait_idle(5000);
        check_strobes("pushpop", 1'b1);

        // Reset during WAIT_A aborts the pair and forgets the last register
        push(8'h70, 8'h71, w);
        wait_strobes(1, 1000);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_write", 32'(write), 32'd0);
        chk("midrst_addr", 32'(addr), 32'd0);
        chk("midrst_dout", 32'(dout), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_level", 32'(level), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_last_vld = 1'b0;
        expq.delete();
        chk("midrst_pre_count", 32'(obs.size()), 32'd1);
        chk("midrst_pre_strobe", {23'd0, obs[0].a, obs[0].d}, {23'd0, 1'b0, 8'h70});
        obs.delete();
        repeat (200) @(negedge clk);
        chk("midrst_no_data", 32'(obs.size()), 32'd0);
        push(8'h70, 8'h72, w);
        wait_idle(2000);
        check_strobes("after_rst", 1'b1);

        // Random requests and random cen, wrapping the FIFO several times
        cen_mode = 2;
        for (int i = 0; i < 14; i++) begin
            r = 8'h10 + 8'($urandom_range(0, 2));
            push(r, 8'($urandom), w);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle(20000);
        check_strobes("random", 1'b0);
        chk("random_level_end", 32'(level), 32'd0);

        // SKIP_SAME=0 instance: repeated register still gets an address strobe
        cen_mode = 1;
        r0_reg = 8'h30; r0_val = 8'h11; r0_valid = 1'b1;
        @(negedge clk);
        r0_val = 8'h22;
        @(negedge clk);
        r0_valid = 1'b0;
        w = 0;
        while ((busy0 !== 1'b0 || obs0.size() < 4) && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("noskip_count", 32'(obs0.size()), 32'd4);
        chk("noskip_s0", {23'd0, obs0[0].a, obs0[0].d}, {23'd0, 1'b0, 8'h30});
        chk("noskip_s1", {23'd0, obs0[1].a, obs0[1].d}, {23'd0, 1'b1, 8'h11});
        chk("noskip_s2", {23'd0, obs0[2].a, obs0[2].d}, {23'd0, 1'b0, 8'h30});
        chk("noskip_s3", {23'd0, obs0[3].a, obs0[3].d}, {23'd0, 1'b1, 8'h22});
        chk_ge("noskip_gap1", obs0[1].t - obs0[0].t, 2);
        chk_ge("noskip_gap2", obs0[2].t - obs0[1].t, 3);
        chk_ge("noskip_gap3", obs0[3].t - obs0[2].t, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
